// File: rtl/regfile_bist_if.sv
// regfile_bist_if: request/response bundle between the BIST initiator and the register file
interface regfile_bist_if #(
    parameter int reg_w = 5,
    parameter int mem_w = 32
);
    logic [reg_w-1:0] rs1;
    logic [reg_w-1:0] rs2;
    logic [reg_w-1:0] rd;
    logic             we;
    logic [mem_w-1:0] indata;
    logic [mem_w-1:0] rv1;
    logic [mem_w-1:0] rv2;
    modport master(output rs1, rs2, rd, we, indata, input rv1, rv2);
    modport slave(input rs1, rs2, rd, we, indata, output rv1, rv2);
endinterface

// File: rtl/regfile_bist.sv
// regfile_bist: two-phase write/read-back self test of the 32-entry register file
module regfile_bist #(
    parameter int               reg_w = 5,
    parameter int               mem_w = 32,
    parameter logic [mem_w-1:0] SEED  = 32'hA5A5_5A5A
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    regfile_bist_if.master   rf,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [6:0]       err_count,
    output logic [reg_w-1:0] fail_addr
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
    state_t           st;
    logic             phase;
    logic [reg_w-1:0] addr;
    logic [reg_w-1:0] a_next;
    logic             m1;
    logic             m2;
    logic [6:0]       err_next;

    function automatic logic [mem_w-1:0] pattern(input logic [reg_w-1:0] a, input logic ph);
        return ph ? ~(SEED ^ mem_w'(a)) : SEED ^ mem_w'(a);
    endfunction

    function automatic logic [mem_w-1:0] exp_val(input logic [reg_w-1:0] a, input logic ph);
        return a == '0 ? '0 : pattern(a, ph);
    endfunction

    // read-port mismatches only feed registered state, never an output directly
    always_comb begin
        m1       = rf.rv1 != exp_val(rf.rs1, phase);
        m2       = rf.rv2 != exp_val(rf.rs2, phase);
        err_next = err_count + 7'(m1) + 7'(m2);
        a_next   = addr + 1'b1;
    end

    // sequencer: walks WRITE/READ over both phases and accumulates the verdict
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st        <= IDLE;
            phase     <= 1'b0;
            addr      <= '0;
            rf.we     <= 1'b0;
            rf.rs1    <= '0;
            rf.rs2    <= '0;
            rf.rd     <= '0;
            rf.indata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
        end else begin
            done <= 1'b0;
            case (st)
                IDLE: if (start) begin
                    st        <= WRITE;
                    phase     <= 1'b0;
                    addr      <= '0;
                    err_count <= '0;
                    fail_addr <= '0;
                    pass      <= 1'b0;
                    busy      <= 1'b1;
                    rf.we     <= 1'b1;
                    rf.rd     <= '0;
                    rf.indata <= pattern('0, 1'b0);
                end
                WRITE: if (addr == '1) begin
                    st        <= READ;
                    addr      <= '0;
                    rf.we     <= 1'b0;
                    rf.rd     <= '0;
                    rf.indata <= '0;
                    rf.rs1    <= '0;
                    rf.rs2    <= reg_w'(1);
                end else begin
                    addr      <= a_next;
                    rf.rd     <= a_next;
                    rf.indata <= pattern(a_next, phase);
                end
                READ: begin
                    err_count <= err_next;
                    if (err_count == '0 && (m1 || m2))
                        fail_addr <= m1 ? rf.rs1 : rf.rs2;
                    if (addr[reg_w-2:0] == '1) begin
                        addr   <= '0;
                        rf.rs1 <= '0;
                        rf.rs2 <= '0;
                        if (!phase) begin
                            st        <= WRITE;
                            phase     <= 1'b1;
                            rf.we     <= 1'b1;
                            rf.rd     <= '0;
                            rf.indata <= pattern('0, 1'b1);
                        end else begin
                            st   <= DONE;
                            busy <= 1'b0;
                            done <= 1'b1;
                            pass <= err_next == '0;
                        end
                    end else begin
                        addr   <= a_next;
                        rf.rs1 <= {a_next[reg_w-2:0], 1'b0};
                        rf.rs2 <= {a_next[reg_w-2:0], 1'b1};
                    end
                end
                DONE: st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_bist.sv
// tb_regfile_bist: randomized fault-injection bench for regfile_bist with a behavioural regfile model
module tb_regfile_bist;
    localparam logic [31:0] SEED = 32'hA5A5_5A5A;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        pass;
    logic [6:0]  err_count;
    logic [4:0]  fail_addr;
    int          n_checks = 0;
    int          n_errors = 0;
    int          kind = 0;
    int          f_reg = 0;
    int          f_bit = 0;
    logic        f_val = 1'b0;
    logic [31:0] mem [32];
    logic [36:0] wlog [$];

    regfile_bist_if #(.reg_w(5), .mem_w(32)) rf();

    regfile_bist #(.reg_w(5), .mem_w(32), .SEED(SEED)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .rf(rf),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_count(err_count),
        .fail_addr(fail_addr)
    );

    always #5 clk = ~clk;

    // kind: 0 ideal, 1 stuck bit on one register, 2 address bit 4 ignored, 3 reg 0 reads all ones
    function automatic int widx(input logic [4:0] a, input int k);
        return k == 2 ? int'(a & 5'd15) : int'(a);
    endfunction

    function automatic logic [31:0] rdval(input logic [4:0] a, input logic [31:0] stored,
                                          input int k, input int r, input int b, input logic v);
        logic [31:0] x;
        x = a == 5'd0 ? (k == 3 ? 32'hFFFF_FFFF : 32'h0) : stored;
        if (k == 1 && int'(a) == r) x[b] = v;
        return x;
    endfunction

    assign rf.rv1 = rdval(rf.rs1, mem[widx(rf.rs1, kind)], kind, f_reg, f_bit, f_val);
    assign rf.rv2 = rdval(rf.rs2, mem[widx(rf.rs2, kind)], kind, f_reg, f_bit, f_val);

    always @(posedge clk) begin
        if (rf.we) begin
            wlog.push_back({rf.rd, rf.indata});
            if (rf.rd != 5'd0) mem[widx(rf.rd, kind)] <= rf.indata;
        end
    end

    function automatic logic [31:0] base(input int a, input int ph);
        return ph != 0 ? ~(SEED ^ 32'(a)) : SEED ^ 32'(a);
    endfunction

    function automatic logic [31:0] want(input int a, input int ph);
        return a == 0 ? 32'h0 : base(a, ph);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic predict(output int e, output int fa);
        logic [31:0] pm [32];
        e = 0;
        fa = 0;
        for (int i = 0; i < 32; i++) pm[i] = 32'h0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int a = 1; a < 32; a++) pm[widx(5'(a), kind)] = base(a, ph);
            for (int a = 0; a < 32; a++)
                if (rdval(5'(a), pm[widx(5'(a), kind)], kind, f_reg, f_bit, f_val) !== want(a, ph)) begin
                    if (e == 0) fa = a;
                    e++;
                end
        end
    endtask

    task automatic do_run(input string tag, input bit tog);
        int e, fa, cyc, busy_n, bad, w;
        predict(e, fa);
        wlog.delete();
        w = $urandom_range(1, 3);
        start = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        busy_n = 0;
        while (done !== 1'b1 && cyc < 200) begin
            if (busy === 1'b1) busy_n++;
            start = (tog && cyc < 90) ? 1'($urandom) : (cyc < w);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check({tag, " done_cyc"}, cyc, 97);
        check({tag, " busy_cycles"}, busy_n, 96);
        check({tag, " pass"}, pass, e == 0);
        check({tag, " err_count"}, err_count, e);
        check({tag, " fail_addr"}, fail_addr, fa);
        check({tag, " writes"}, wlog.size(), 64);
        bad = 0;
        foreach (wlog[i])
            if (wlog[i] !== {5'(i % 32), base(i % 32, i / 32)}) bad++;
        check({tag, " wdata_bad"}, bad, 0);
        @(posedge clk); #1;
        check({tag, " done_pulse"}, done, 0);
        check({tag, " err_hold"}, err_count, e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, nd, d1, d2;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", {busy, done, pass, err_count, fail_addr, rf.we, rf.rs1, rf.rs2, rf.rd}, 0);
        check("reset_indata", rf.indata, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        kind = 0;
        do_run("ideal", 0);
        kind = 1; f_reg = 5; f_bit = 3; f_val = 1'b0;
        do_run("stuck5", 0);
        check("stuck5 err1", err_count, 1);
        check("stuck5 fa5", fail_addr, 5);
        kind = 2;
        do_run("alias", 0);
        check("alias err30", err_count, 30);
        check("alias fa1", fail_addr, 1);
        kind = 3;
        do_run("r0bad", 0);
        check("r0bad err2", err_count, 2);
        check("r0bad fa0", fail_addr, 0);
        kind = 0;
        do_run("toggle", 1);

        kind = 1; f_reg = 5; f_bit = 3; f_val = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("pre_rst err", err_count, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_abort outs", {busy, done, pass, err_count, fail_addr, rf.we, rf.rs1, rf.rs2, rf.rd}, 0);
        check("rst_abort indata", rf.indata, 0);
        rst_n = 1'b1;
        nd = 0;
        repeat (120) begin
            @(posedge clk); #1;
            if (done === 1'b1) nd++;
        end
        check("rst no_done", nd, 0);
        kind = 0;
        do_run("post_rst", 0);

        kind = 1;
        start = 1'b1;
        @(posedge clk); #1;
        cyc = 1; nd = 0; d1 = 0; d2 = 0;
        while (cyc < 250) begin
            if (done === 1'b1) begin
                nd++;
                if (nd == 1) d1 = cyc;
                else if (nd == 2) d2 = cyc;
            end
            if (cyc == 98) check("held err_hold", err_count, 1);
            if (cyc == 99) check("held err_clr", {busy, err_count}, {1'b1, 7'd0});
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("held pulses", nd, 2);
        check("held done1", d1, 97);
        check("held done2", d2, 195);
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("held third_done", done, 1);
        @(posedge clk); #1;

        repeat (6) begin
            kind = $urandom_range(0, 3);
            f_reg = $urandom_range(0, 31);
            f_bit = $urandom_range(0, 31);
            f_val = 1'($urandom);
            do_run("rand", 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
